// File: rtl/pbkdf2_pkg.sv
// Shared types and sizes for the PBKDF2-HMAC-SHA256 block controller.
// StDrain is only reachable when the design is built with PBKDF2_ABORT_EN.
package pbkdf2_pkg;

    localparam int unsigned KEY_W          = 512;
    localparam int unsigned MSG_W          = 512;
    localparam int unsigned PRF_W          = 256;
    localparam int unsigned LEN_W          = 6;
    localparam int unsigned MAX_SALT_BYTES = 59;
    localparam int unsigned INT_BYTES      = 4;
    localparam int unsigned INT_W          = 8 * INT_BYTES;

    typedef enum logic [2:0] {
        StIdle,
        StSend,
        StWait,
        StDone,
        StDrain
    } pbkdf2_state_e;

endpackage

// File: rtl/pbkdf2_msg_fmt.sv
// Builds the first-iteration HMAC message: salt bytes followed by the
// big-endian block index, every byte past the length forced to zero.
module pbkdf2_msg_fmt
    import pbkdf2_pkg::*;
(
    input  logic [MSG_W-1:0] salt_i,
    input  logic [LEN_W-1:0] salt_len_i,
    input  logic [INT_W-1:0] blk_i,
    output logic [MSG_W-1:0] msg_o,
    output logic [LEN_W-1:0] len_o
);

    logic [LEN_W+2:0] shamt;
    logic [MSG_W-1:0] salt_mask;
    logic [MSG_W-1:0] int_field;

    // Mask off salt bytes beyond salt_len and splice the index right after them.
    always_comb begin
        shamt     = {salt_len_i, 3'b000};
        salt_mask = ~({MSG_W{1'b1}} >> shamt);
        int_field = {blk_i, {(MSG_W-INT_W){1'b0}}} >> shamt;
        msg_o     = (salt_i & salt_mask) | int_field;
        len_o     = salt_len_i + LEN_W'(INT_BYTES);
    end

endmodule

// File: rtl/pbkdf2_f_ctrl.sv
// Iteration controller computing F(P, S, c, i) = U1 ^ ... ^ Uc on top of an
// hmac_sha256 core. Optional abort support is enabled with PBKDF2_ABORT_EN.
module pbkdf2_f_ctrl
    import pbkdf2_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
`ifdef PBKDF2_ABORT_EN
    input  logic             abort_i,
`endif
    input  logic             v_i,
    output logic             r_o,
    input  logic [KEY_W-1:0] pass_i,
    input  logic [MSG_W-1:0] salt_i,
    input  logic [LEN_W-1:0] salt_len_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] blk_i,
    output logic             v_o,
    input  logic             r_i,
    output logic [PRF_W-1:0] dk_o,
    output logic             err_o,
    output logic [KEY_W-1:0] hmac_key_o,
    output logic [MSG_W-1:0] hmac_msg_o,
    output logic [LEN_W-1:0] hmac_len_o,
    output logic             hmac_v_o,
    input  logic             hmac_r_i,
    input  logic [PRF_W-1:0] hmac_prf_i,
    input  logic             hmac_v_i,
    output logic             hmac_r_o
);

    pbkdf2_state_e    state_q, state_d;
    logic [KEY_W-1:0] pass_q;
    logic [MSG_W-1:0] salt_q;
    logic [LEN_W-1:0] salt_len_q;
    logic [CNT_W-1:0] blk_q;
    logic [CNT_W-1:0] c_q;
    logic [CNT_W-1:0] j_q;
    logic [PRF_W-1:0] u_q;
    logic [PRF_W-1:0] acc_q;
    logic             err_q;

    logic [MSG_W-1:0] u1_msg;
    logic [LEN_W-1:0] u1_len;
    logic [INT_W-1:0] blk_int;
    logic             salt_bad;
    logic             job_acc;
    logic             req_fire;
    logic             rsp_fire;
    logic             res_fire;
    logic             last_iter;

    assign blk_int   = INT_W'(blk_q);
    assign salt_bad  = salt_len_i > LEN_W'(MAX_SALT_BYTES);
    assign job_acc   = v_i & r_o;
    assign req_fire  = (state_q == StSend) & hmac_r_i;
    assign rsp_fire  = (state_q == StWait) & hmac_v_i;
    assign res_fire  = v_o & r_i;
    assign last_iter = (j_q == c_q);

    pbkdf2_msg_fmt u_msg_fmt (
        .salt_i     (salt_q),
        .salt_len_i (salt_len_q),
        .blk_i      (blk_int),
        .msg_o      (u1_msg),
        .len_o      (u1_len)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (job_acc) state_d = salt_bad ? StDone : StSend;
            end
            StSend: begin
                if (req_fire) state_d = StWait;
`ifdef PBKDF2_ABORT_EN
                // A request accepted in the abort cycle still owes us a response.
                if (abort_i) state_d = req_fire ? StDrain : StIdle;
`endif
            end
            StWait: begin
                if (rsp_fire) state_d = last_iter ? StDone : StSend;
`ifdef PBKDF2_ABORT_EN
                // If the response lands in the abort cycle it is already consumed.
                if (abort_i) state_d = rsp_fire ? StIdle : StDrain;
`endif
            end
            StDone: begin
                if (res_fire) state_d = StIdle;
`ifdef PBKDF2_ABORT_EN
                if (abort_i) state_d = StIdle;
`endif
            end
`ifdef PBKDF2_ABORT_EN
            StDrain: begin
                if (hmac_v_i) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Job latch, iteration counter and U / accumulator datapath.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pass_q     <= '0;
            salt_q     <= '0;
            salt_len_q <= '0;
            blk_q      <= '0;
            c_q        <= '0;
            j_q        <= '0;
            u_q        <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            if (job_acc) begin
                pass_q     <= pass_i;
                salt_q     <= salt_i;
                salt_len_q <= salt_len_i;
                blk_q      <= blk_i;
                c_q        <= (cnt_i == '0) ? CNT_W'(1) : cnt_i;
                j_q        <= CNT_W'(1);
                u_q        <= '0;
                acc_q      <= '0;
                err_q      <= salt_bad;
            end
            if (rsp_fire) begin
                u_q   <= hmac_prf_i;
                acc_q <= acc_q ^ hmac_prf_i;
                // Hold j at c on the last response so it never wraps.
                if (!last_iter) j_q <= j_q + CNT_W'(1);
            end
            if (res_fire) err_q <= 1'b0;
        end
    end

    // Handshake and data outputs decoded straight from state.
    always_comb begin
        r_o        = 1'b0;
        v_o        = 1'b0;
        dk_o       = '0;
        err_o      = 1'b0;
        hmac_v_o   = 1'b0;
        hmac_r_o   = 1'b0;
        hmac_key_o = '0;
        hmac_msg_o = '0;
        hmac_len_o = '0;
        unique case (state_q)
            StIdle: r_o = ~rst_i;
            StSend: begin
                hmac_v_o   = 1'b1;
                hmac_key_o = pass_q;
                if (j_q == CNT_W'(1)) begin
                    hmac_msg_o = u1_msg;
                    hmac_len_o = u1_len;
                end else begin
                    hmac_msg_o = {u_q, {(MSG_W-PRF_W){1'b0}}};
                    hmac_len_o = LEN_W'(PRF_W / 8);
                end
            end
            StWait: hmac_r_o = 1'b1;
            StDone: begin
                v_o   = 1'b1;
`ifdef PBKDF2_ABORT_EN
                v_o   = ~abort_i;
`endif
                dk_o  = acc_q;
                err_o = err_q;
            end
`ifdef PBKDF2_ABORT_EN
            StDrain: hmac_r_o = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
